// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the two-requester RAM port arbiter.
package mem_arb_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 3;
    localparam int NUM_REQ    = 2;

    // Requester index: 0 or 1.
    typedef logic req_id_t;

    // Read-response tag carried alongside the RAM read latency.
    typedef struct packed {
        logic    valid;
        req_id_t id;
    } rsp_tag_t;

    // One-hot strobe for a requester id.
    function automatic logic [NUM_REQ-1:0] id_to_onehot(input req_id_t id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way arbiter. Default build: round-robin, the pointer names the
// requester that wins a tie and moves only on an accepted handshake.
// With ARB_FIXED_PRIO_EN defined, requester 0 always wins and the pointer
// does not exist.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       accept,
    output logic [1:0] grant
);

`ifdef ARB_FIXED_PRIO_EN

    // Clock, reset and accept have no role without a pointer.
    logic unused_ports;
    assign unused_ports = clk ^ rst ^ accept;

    // Fixed priority: requester 0 first.
    always_comb begin
        grant = 2'b00;
        if (valid[0])
            grant = 2'b01;
        else if (valid[1])
            grant = 2'b10;
    end

`else

    req_id_t prio;

    // Pointer: after a grant to requester i, the other one wins the next tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            prio <= 1'b0;
        else if (accept)
            prio <= grant[0];
    end

    // Grant the lone requester, or the pointer's choice on contention.
    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = prio ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one registered-read RAM port between two requesters.
// Accepted commands are registered onto the RAM port one cycle later; reads
// return to their requester two cycles after acceptance through a two-stage
// tag pipeline. Optional build macro: ARB_FIXED_PRIO_EN (fixed priority
// to requester 0 instead of round-robin).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req_valid,
    input  logic [1:0]            req_we,
    input  logic [2*ADDR_W-1:0]   req_addr,
    input  logic [2*DATA_W-1:0]   req_wdata,
    output logic [1:0]            req_ready,
    output logic [1:0]            rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_din,
    input  logic [DATA_W-1:0]     mem_dout
);

    logic     [1:0] grant;
    logic           accept;
    req_id_t        gnt_id;
    rsp_tag_t       tag_s1;
    rsp_tag_t       tag_s2;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .valid  (req_valid),
        .accept (accept),
        .grant  (grant)
    );

    // Grants are suppressed while reset is held so nothing is handshaken.
    always_comb begin
        req_ready = rst ? 2'b00 : grant;
        accept    = |(req_valid & req_ready);
        gnt_id    = req_ready[1];
    end

    // RAM port registers; address and data hold when nothing is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
        end else begin
            mem_en <= accept;
            mem_we <= accept & req_we[gnt_id];
            if (accept) begin
                mem_addr <= req_addr[int'(gnt_id)*ADDR_W +: ADDR_W];
                mem_din  <= req_wdata[int'(gnt_id)*DATA_W +: DATA_W];
            end
        end
    end

    // Read tags follow the RAM latency; reset drops anything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_s1 <= '0;
            tag_s2 <= '0;
        end else begin
            tag_s1.valid <= accept & ~req_we[gnt_id];
            tag_s1.id    <= gnt_id;
            tag_s2       <= tag_s1;
        end
    end

    // Response strobe and data, forced to zero when no response is due.
    always_comb begin
        rsp_valid = tag_s2.valid ? id_to_onehot(tag_s2.id) : 2'b00;
        rsp_rdata = tag_s2.valid ? mem_dout : '0;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a registered-read RAM model.
// Build with ARB_FIXED_PRIO_EN to check the fixed-priority variant.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_we;
    logic [5:0]  req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [2:0]  mem_addr;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout = 8'h00;

    logic [7:0]  ram [8];

    int n_vec = 0;
    int n_bad = 0;

    mem_port_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout)
    );

    always #5 clk = ~clk;

    // RAM with one-cycle registered read.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we)
                ram[mem_addr] <= mem_din;
            else
                mem_dout <= ram[mem_addr];
        end
    end

    typedef struct {
        logic [1:0] valid;
        logic [1:0] we;
        logic [2:0] a0;
        logic [2:0] a1;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [1:0] ready;
        logic       en;
        logic       mwe;
        logic [2:0] maddr;
        logic [7:0] mdin;
        logic [1:0] rsp;
        logic [7:0] rdata;
    } vec_t;

    vec_t vecs [12];

    task automatic drive(input logic [1:0] v, input logic [1:0] we,
                         input logic [2:0] a0, input logic [2:0] a1,
                         input logic [7:0] d0, input logic [7:0] d1);
        req_valid = v;
        req_we    = we;
        req_addr  = {a1, a0};
        req_wdata = {d1, d0};
    endtask

    task automatic check_all(input string name, input logic [1:0] rdy,
                             input logic en, input logic mwe,
                             input logic [2:0] ma, input logic [7:0] md,
                             input logic [1:0] rv, input logic [7:0] rd);
        logic [24:0] act;
        logic [24:0] exp;
        act = {req_ready, mem_en, mem_we, mem_addr, mem_din, rsp_valid, rsp_rdata};
        exp = {rdy, en, mwe, ma, md, rv, rd};
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got ready=%b en=%b we=%b addr=%0d din=%h rsp=%b rdata=%h, need ready=%b en=%b we=%b addr=%0d din=%h rsp=%b rdata=%h",
                     name, req_ready, mem_en, mem_we, mem_addr, mem_din, rsp_valid, rsp_rdata,
                     rdy, en, mwe, ma, md, rv, rd);
        end
    endtask

    task automatic check_rsp(input string name, input logic [1:0] rdy,
                             input logic en, input logic [1:0] rv,
                             input logic [7:0] rd);
        logic [12:0] act;
        logic [12:0] exp;
        act = {req_ready, mem_en, rsp_valid, rsp_rdata};
        exp = {rdy, en, rv, rd};
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got ready=%b en=%b rsp=%b rdata=%h, need ready=%b en=%b rsp=%b rdata=%h",
                     name, req_ready, mem_en, rsp_valid, rsp_rdata, rdy, en, rv, rd);
        end
    endtask

    logic [1:0] exp_g  [8];
    logic [1:0] exp_r  [8];
    logic [7:0] exp_d  [8];
    logic [2:0] al0    [3];
    logic [2:0] al1    [3];
    int         idx0;
    int         idx1;
    logic [1:0] seen;

    initial begin
        // cycle-by-cycle table: inputs, then outputs expected in that cycle
        vecs[0]  = '{2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 3'd0, 8'h00, 2'b00, 8'h00};
        vecs[1]  = '{2'b01, 2'b01, 3'd3, 3'd0, 8'hA5, 8'h00, 2'b01, 1'b0, 1'b0, 3'd0, 8'h00, 2'b00, 8'h00};
        vecs[2]  = '{2'b10, 2'b00, 3'd0, 3'd3, 8'h00, 8'h5C, 2'b10, 1'b1, 1'b1, 3'd3, 8'hA5, 2'b00, 8'h00};
        vecs[3]  = '{2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 2'b00, 1'b1, 1'b0, 3'd3, 8'h5C, 2'b00, 8'h00};
        vecs[4]  = '{2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 3'd3, 8'h5C, 2'b10, 8'hA5};
        vecs[5]  = '{2'b11, 2'b11, 3'd5, 3'd6, 8'h3C, 8'hC3, 2'b01, 1'b0, 1'b0, 3'd3, 8'h5C, 2'b00, 8'h00};
        vecs[6]  = '{2'b10, 2'b10, 3'd0, 3'd6, 8'h00, 8'hC3, 2'b10, 1'b1, 1'b1, 3'd5, 8'h3C, 2'b00, 8'h00};
        vecs[7]  = '{2'b11, 2'b00, 3'd6, 3'd5, 8'h11, 8'h22, 2'b01, 1'b1, 1'b1, 3'd6, 8'hC3, 2'b00, 8'h00};
        vecs[8]  = '{2'b10, 2'b00, 3'd0, 3'd5, 8'h00, 8'h22, 2'b10, 1'b1, 1'b0, 3'd6, 8'h11, 2'b00, 8'h00};
        vecs[9]  = '{2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 2'b00, 1'b1, 1'b0, 3'd5, 8'h22, 2'b01, 8'hC3};
        vecs[10] = '{2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 3'd5, 8'h22, 2'b10, 8'h3C};
        vecs[11] = '{2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 3'd5, 8'h22, 2'b00, 8'h00};

        // reset held with both requesters asserting: nothing granted
        rst = 1'b1;
        drive(2'b11, 2'b00, 3'd1, 3'd2, 8'h00, 8'h00);
        #2;
        @(negedge clk);
        check_all("in_reset", 2'b00, 1'b0, 1'b0, 3'd0, 8'h00, 2'b00, 8'h00);
        drive(2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // idle after release: every output stays zero
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_all($sformatf("idle_%0d", k), 2'b00, 1'b0, 1'b0, 3'd0, 8'h00, 2'b00, 8'h00);
            @(posedge clk);
            #1;
        end

        // table vectors
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].valid, vecs[i].we, vecs[i].a0, vecs[i].a1, vecs[i].d0, vecs[i].d1);
            @(negedge clk);
            check_all($sformatf("vec_%0d", i), vecs[i].ready, vecs[i].en, vecs[i].mwe,
                      vecs[i].maddr, vecs[i].mdin, vecs[i].rsp, vecs[i].rdata);
            @(posedge clk);
            #1;
        end

        // both requesters stream three reads each; RAM holds 3=A5 5=3C 6=C3
        al0[0] = 3'd3; al0[1] = 3'd5; al0[2] = 3'd6;
        al1[0] = 3'd6; al1[1] = 3'd5; al1[2] = 3'd3;
`ifdef ARB_FIXED_PRIO_EN
        exp_g = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00};
        exp_r = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10};
        exp_d = '{8'h00, 8'h00, 8'hA5, 8'h3C, 8'hC3, 8'hC3, 8'h3C, 8'hA5};
`else
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b00, 2'b00};
        exp_r = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
        exp_d = '{8'h00, 8'h00, 8'hA5, 8'hC3, 8'h3C, 8'h3C, 8'hC3, 8'hA5};
`endif
        idx0 = 0;
        idx1 = 0;
        for (int k = 0; k < 8; k++) begin
            drive({idx1 < 3, idx0 < 3}, 2'b00,
                  (idx0 < 3) ? al0[idx0] : 3'd0,
                  (idx1 < 3) ? al1[idx1] : 3'd0, 8'h00, 8'h00);
            @(negedge clk);
            check_rsp($sformatf("stream_%0d", k), exp_g[k], (k >= 1 && k <= 6),
                      exp_r[k], exp_d[k]);
            seen = req_ready & req_valid;
            @(posedge clk);
            #1;
            if (seen[0]) idx0++;
            if (seen[1]) idx1++;
        end

        // read accepted, then reset pulsed: its response must never appear
        drive(2'b01, 2'b00, 3'd3, 3'd0, 8'h00, 8'h00);
        @(negedge clk);
        check_rsp("rst_rd_accept", 2'b01, 1'b0, 2'b00, 8'h00);
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00);
        @(negedge clk);
        check_all("rst_pulse", 2'b00, 1'b0, 1'b0, 3'd0, 8'h00, 2'b00, 8'h00);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(2'b10, 2'b00, 3'd0, 3'd5, 8'h00, 8'h00);
        @(negedge clk);
        check_all("post_rst_grant", 2'b10, 1'b0, 1'b0, 3'd0, 8'h00, 2'b00, 8'h00);
        @(posedge clk);
        #1;
        drive(2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00);
        @(negedge clk);
        check_all("post_rst_mem", 2'b00, 1'b1, 1'b0, 3'd5, 8'h00, 2'b00, 8'h00);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_all("post_rst_rsp", 2'b00, 1'b0, 1'b0, 3'd5, 8'h00, 2'b10, 8'h3C);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_all("post_rst_quiet", 2'b00, 1'b0, 1'b0, 3'd5, 8'h00, 2'b00, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
